wra_prefetch_dma: RTL and testbench

WRA_PREFETCH_DMA -- requirements
Module: wra_prefetch_dma

---
 rtl/wra_prefetch_dma_pkg.sv | 15 +
 rtl/wra_prefetch_dma_dly_pipe.sv | 45 ++++
 rtl/wra_prefetch_dma.sv | 184 ++++++++++++++++++
 tb/tb_wra_prefetch_dma.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wra_prefetch_dma_pkg.sv
// Shared types for the WRA prefetch DMA: FSM state encoding
// and default address/size widths.
package wra_prefetch_dma_pkg;

  localparam int WRA_AW = 16;
  localparam int WRA_SW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/wra_prefetch_dma_dly_pipe.sv
// wra_dly_pipe: D-stage delay line of W-bit words, MSB is valid.
// Ports: clk, rst_n (async clear), flush (sync clear), in_d, out_q, vld (per-stage MSB).
module wra_dly_pipe #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] in_d,
  output logic [W-1:0] out_q,
  output logic [D-1:0] vld
);

  logic [D-1:0][W-1:0] stg_q;
  logic [D-1:0][W-1:0] stg_d;

  always_comb begin
    stg_d = '0;
    if (!flush) begin
      stg_d[0] = in_d;
      for (int i = 1; i < D; i++) begin
        stg_d[i] = stg_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign out_q = stg_q[D-1];

  always_comb begin
    vld = '0;
    for (int i = 0; i < D; i++) begin
      vld[i] = stg_q[i][W-1];
    end
  end

endmodule

// File: rtl/wra_prefetch_dma.sv
// Prefetch DMA: streams data FIFO words and filter RAM words into the WRA.
// Ports: cfg_* shadowed in IDLE, start/abort control, fifo_* data side,
// fram_* filter RAM reads, we_*/fwra_addr WRA writes, busy/done status.
// Optional busy_cycles perf counter when WRA_DMA_PERF_EN is defined.
module wra_prefetch_dma
  import wra_prefetch_dma_pkg::*;
#(
  parameter int AW       = WRA_AW,
  parameter int SW       = WRA_SW,
  parameter int FRAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  input  logic [AW-1:0] cfg_faddr,
  input  logic [SW-1:0] cfg_fsize,
  input  logic [SW-1:0] cfg_dsize,
  input  logic          start,
  input  logic          abort,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  output logic          we_data,
  output logic          fram_en,
  output logic [AW-1:0] fram_addr,
  output logic          we_filter,
  output logic [AW-1:0] fwra_addr,
  output logic          busy,
  output logic          done
`ifdef WRA_DMA_PERF_EN
  ,
  output logic [31:0]   busy_cycles
`endif
);

  dma_state_e state_q, state_d;
  logic [AW-1:0] faddr_q, faddr_d;
  logic [SW-1:0] fsize_q, fsize_d;
  logic [SW-1:0] dsize_q, dsize_d;
  logic [SW-1:0] fcnt_q, fcnt_d;
  logic [SW-1:0] dcnt_q, dcnt_d;

  logic                flush;
  logic                pend;
  logic [AW:0]         fp_in;
  logic [AW:0]         fp_out;
  logic [FRAM_LAT-1:0] fvld;
  logic [FRAM_LAT-1:0] fvld_sh;
  logic [0:0]          dvld;
  logic [0:0]          dvld_sh;

  always_comb begin
    state_d   = state_q;
    faddr_d   = faddr_q;
    fsize_d   = fsize_q;
    dsize_d   = dsize_q;
    fcnt_d    = fcnt_q;
    dcnt_d    = dcnt_q;
    fifo_rd   = 1'b0;
    fram_en   = 1'b0;
    fram_addr = '0;
    flush     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        fcnt_d = '0;
        dcnt_d = '0;
        if (cfg_valid) begin
          faddr_d = cfg_faddr;
          fsize_d = cfg_fsize;
          dsize_d = cfg_dsize;
        end
        if (start && !abort) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        fifo_rd = !fifo_empty && (dcnt_q < dsize_q);
        fram_en = fcnt_q < fsize_q;
        if (fram_en) fram_addr = faddr_q + AW'(fcnt_q);
        fcnt_d = fcnt_q + SW'(fram_en);
        dcnt_d = dcnt_q + SW'(fifo_rd);
        if (abort) begin
          // the read issued this cycle is dropped by the flush too
          flush   = 1'b1;
          fcnt_d  = '0;
          dcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (fcnt_d == fsize_q && dcnt_d == dsize_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          fcnt_d  = '0;
          dcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (!pend) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        fcnt_d  = '0;
        dcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      faddr_q <= '0;
      fsize_q <= '0;
      dsize_q <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      faddr_q <= faddr_d;
      fsize_q <= fsize_d;
      dsize_q <= dsize_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign fp_in = fram_en ? {1'b1, AW'(fcnt_q)} : '0;

  wra_dly_pipe #(
    .W (AW + 1),
    .D (FRAM_LAT)
  ) u_fpipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .in_d  (fp_in),
    .out_q (fp_out),
    .vld   (fvld)
  );

  wra_dly_pipe #(
    .W (1),
    .D (1)
  ) u_dpipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .in_d  (fifo_rd),
    .out_q (we_data),
    .vld   (dvld)
  );

  // in flight = valid in any stage except the one on the output now
  assign fvld_sh = fvld << 1;
  assign dvld_sh = dvld << 1;
  assign pend    = (|fvld_sh) | (|dvld_sh);

  assign we_filter = fp_out[AW];
  assign fwra_addr = fp_out[AW-1:0];
  assign busy      = state_q != ST_IDLE;
  assign done      = state_q == ST_DONE;

`ifdef WRA_DMA_PERF_EN
  logic [31:0] bcyc_q, bcyc_d;

  always_comb begin
    bcyc_d = bcyc_q;
    if (state_q == ST_IDLE) begin
      if (start && !abort) bcyc_d = '0;
    end else if (bcyc_q != '1) begin
      bcyc_d = bcyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcyc_q <= '0;
    end else begin
      bcyc_q <= bcyc_d;
    end
  end

  assign busy_cycles = bcyc_q;
`endif

endmodule

// File: tb/tb_wra_prefetch_dma.sv
// Directed bench for wra_prefetch_dma with a per-cycle event model.
module tb_wra_prefetch_dma;

  localparam int LAT = 1;
  localparam int NW  = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_faddr = '0;
  logic [15:0] cfg_fsize = '0;
  logic [15:0] cfg_dsize = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fifo_empty = 1'b0;
  logic        fifo_rd, we_data, fram_en, we_filter, busy, done;
  logic [15:0] fram_addr, fwra_addr;
`ifdef WRA_DMA_PERF_EN
  logic [31:0] busy_cycles;
`endif

  always #5 clk = ~clk;

  wra_prefetch_dma #(
    .AW       (16),
    .SW       (16),
    .FRAM_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_faddr  (cfg_faddr),
    .cfg_fsize  (cfg_fsize),
    .cfg_dsize  (cfg_dsize),
    .start      (start),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .we_data    (we_data),
    .fram_en    (fram_en),
    .fram_addr  (fram_addr),
    .we_filter  (we_filter),
    .fwra_addr  (fwra_addr),
    .busy       (busy),
`ifdef WRA_DMA_PERF_EN
    .busy_cycles(busy_cycles),
`endif
    .done       (done)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  bit          e_rd[NW], e_wd[NW], e_fe[NW], e_wf[NW];
  bit          e_busy[NW], e_done[NW];
  logic [15:0] e_fa[NW], e_fw[NW];
  bit          emp[NW];

  int          rel = 0;
  bit          chk_en = 0;
  int          done_seen;
  int          wd_seen;
  logic [15:0] fa_seen[$];
  logic [15:0] fw_seen[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s rel=%0d act=%h exp=%h", name, rel, act, exp);
  endtask

  // Expected strobes per cycle counted from FETCH entry (rel 0).
  task automatic build(input logic [15:0] fa, input int fs, input int ds,
                       input int ab);
    int cnt, last, nf, dr;
    for (int r = 0; r < NW; r++) begin
      e_rd[r] = 0; e_wd[r] = 0; e_fe[r] = 0; e_wf[r] = 0;
      e_busy[r] = 0; e_done[r] = 0; e_fa[r] = '0; e_fw[r] = '0;
    end
    cnt = 0;
    last = -1;
    for (int r = 0; r < NW; r++) begin
      if (!emp[r] && cnt < ds) begin
        e_rd[r] = 1;
        if (r + 1 < NW) e_wd[r+1] = 1;
        cnt++;
        last = r;
      end
    end
    for (int i = 0; i < fs; i++) begin
      e_fe[i] = 1;
      e_fa[i] = fa + 16'(i);
      if (i + LAT < NW) begin
        e_wf[i+LAT] = 1;
        e_fw[i+LAT] = 16'(i);
      end
    end
    nf = fs;
    if (last + 1 > nf) nf = last + 1;
    if (nf < 1) nf = 1;
    dr = nf + 1;
    if (fs > 0 && fs + LAT > dr) dr = fs + LAT;
    for (int r = 0; r <= dr; r++) e_busy[r] = 1;
    e_done[dr] = 1;
    if (ab >= 0) begin
      for (int r = ab + 1; r < NW; r++) begin
        e_rd[r] = 0; e_wd[r] = 0; e_fe[r] = 0; e_wf[r] = 0;
        e_busy[r] = 0; e_done[r] = 0; e_fa[r] = '0; e_fw[r] = '0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("fifo_rd", 32'(fifo_rd), 32'(e_rd[rel]));
      check("rd_empty", 32'(fifo_rd & fifo_empty), 32'd0);
      check("we_data", 32'(we_data), 32'(e_wd[rel]));
      check("fram_en", 32'(fram_en), 32'(e_fe[rel]));
      check("fram_addr", 32'(fram_addr), 32'(e_fa[rel]));
      check("we_filter", 32'(we_filter), 32'(e_wf[rel]));
      check("fwra_addr", 32'(fwra_addr), 32'(e_fw[rel]));
      check("busy", 32'(busy), 32'(e_busy[rel]));
      check("done", 32'(done), 32'(e_done[rel]));
      if (fram_en) fa_seen.push_back(fram_addr);
      if (we_filter) fw_seen.push_back(fwra_addr);
      if (we_data) wd_seen++;
      if (done) done_seen = rel;
    end
  end

  task automatic chk_quiet(input string tag);
    check({tag, "_fifo_rd"}, 32'(fifo_rd), 32'd0);
    check({tag, "_we_data"}, 32'(we_data), 32'd0);
    check({tag, "_fram_en"}, 32'(fram_en), 32'd0);
    check({tag, "_fram_addr"}, 32'(fram_addr), 32'd0);
    check({tag, "_we_filter"}, 32'(we_filter), 32'd0);
    check({tag, "_fwra_addr"}, 32'(fwra_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic clr_emp();
    for (int r = 0; r < NW; r++) emp[r] = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic run(input logic [15:0] fa, input int fs, input int ds,
                     input int ab, input int len);
    cfg_valid = 1'b1;
    cfg_faddr = fa;
    cfg_fsize = 16'(fs);
    cfg_dsize = 16'(ds);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fa_seen.delete();
    fw_seen.delete();
    wd_seen = 0;
    done_seen = -1;
    build(fa, fs, ds, ab);
    for (int r = 0; r < len; r++) begin
      rel = r;
      fifo_empty = emp[r];
      abort = (r == ab);
      chk_en = 1;
      @(posedge clk);
      #1;
    end
    chk_en = 0;
    abort = 1'b0;
    fifo_empty = 1'b0;
  endtask

  initial begin
    #3;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic run
    clr_emp();
    run(16'h0040, 4, 3, -1, 10);
    check("basic_done_rel", 32'(done_seen), 32'd5);
    check("basic_nwd", 32'(wd_seen), 32'd3);
    check("basic_nfe", 32'(fa_seen.size()), 32'd4);
    if (fa_seen.size() == 4) begin
      check("basic_fa0", 32'(fa_seen[0]), 32'h0040);
      check("basic_fa3", 32'(fa_seen[3]), 32'h0043);
    end
    check("basic_nwf", 32'(fw_seen.size()), 32'd4);
    if (fw_seen.size() == 4) check("basic_fw3", 32'(fw_seen[3]), 32'd3);
`ifdef WRA_DMA_PERF_EN
    check("basic_bcyc", busy_cycles, 32'd6);
    @(posedge clk);
    #1;
    check("basic_bcyc_hold", busy_cycles, 32'd6);
`endif

    // FIFO stall
    clr_emp();
    emp[2] = 1; emp[3] = 1; emp[4] = 1;
    run(16'h0010, 2, 5, -1, 14);
    check("stall_nwd", 32'(wd_seen), 32'd5);
    check("stall_done_rel", 32'(done_seen), 32'd9);

    // zero sizes
    clr_emp();
    run(16'h1234, 0, 0, -1, 6);
    check("zero_done_rel", 32'(done_seen), 32'd2);
    check("zero_nfe", 32'(fa_seen.size()), 32'd0);
    check("zero_nwd", 32'(wd_seen), 32'd0);

    // address wrap
    run(16'hFFFE, 4, 0, -1, 8);
    check("wrap_nfe", 32'(fa_seen.size()), 32'd4);
    if (fa_seen.size() == 4) begin
      check("wrap_fa0", 32'(fa_seen[0]), 32'hFFFE);
      check("wrap_fa1", 32'(fa_seen[1]), 32'hFFFF);
      check("wrap_fa2", 32'(fa_seen[2]), 32'h0000);
      check("wrap_fa3", 32'(fa_seen[3]), 32'h0001);
    end
    check("wrap_nwf", 32'(fw_seen.size()), 32'd4);
    if (fw_seen.size() == 4) begin
      check("wrap_fw0", 32'(fw_seen[0]), 32'd0);
      check("wrap_fw3", 32'(fw_seen[3]), 32'd3);
    end

    // abort on the third filter read, then a clean run
    run(16'h0200, 8, 0, 2, 8);
    check("abort_nfe", 32'(fa_seen.size()), 32'd3);
    check("abort_nwf", 32'(fw_seen.size()), 32'd2);
    check("abort_no_done", 32'(done_seen), 32'hFFFF_FFFF);
    run(16'h0300, 2, 2, -1, 8);
    check("post_abort_done_rel", 32'(done_seen), 32'd3);
    check("post_abort_nwd", 32'(wd_seen), 32'd2);

    // reset in the middle of FETCH
    cfg_valid = 1'b1;
    cfg_faddr = 16'h0500;
    cfg_fsize = 16'd8;
    cfg_dsize = 16'd4;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("prereset_fram_en", 32'(fram_en), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
`ifdef WRA_DMA_PERF_EN
    check("midrst_bcyc", busy_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk_quiet("postrst");
    @(posedge clk);
    #1;
    run(16'h0040, 4, 3, -1, 10);
    check("rerun_done_rel", 32'(done_seen), 32'd5);
    check("rerun_nwf", 32'(fw_seen.size()), 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
